// File: rtl/axi_lite_master_seq.sv
// axi_lite_master_seq: converts single register commands from a valid/ready
// command port into AXI4-Lite write or read transactions, one at a time, and
// returns the slave's result on a valid/ready response port. A sticky timeout
// flag records slow transactions without ever abandoning them.
//
// Handshake rule on every channel (cmd, rsp, aw, w, b, ar, r): a transfer
// happens on the rising edge where valid and ready are both 1. A raised valid
// is held, with a stable payload, until that edge; ready may come at any time.
module axi_lite_master_seq #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [2:0]  AXI_PROT       = 3'b000
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    // AXI4-Lite write address / data / response
    output logic                  m_axi_awvalid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    input  logic                  m_axi_awready,
    output logic                  m_axi_wvalid,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    input  logic                  m_axi_wready,
    input  logic                  m_axi_bvalid,
    input  logic [1:0]            m_axi_bresp,
    output logic                  m_axi_bready,
    // AXI4-Lite read address / data
    output logic                  m_axi_arvalid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    output logic                  m_axi_rready,
    // debug: current FSM state
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESP         = 3'd5
    } state_e;

    // Counter wide enough to hold TIMEOUT_CYCLES itself (its saturation value).
    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    to_flag_q, to_flag_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    rst_done_q;
    logic                    accept;
    logic                    busy;
    logic                    hit;

    assign cmd_ready = rst_done_q && (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Busy states are the ones that count toward the timeout; hit means this
    // cycle is the TIMEOUT_CYCLES-th counted one (or later).
    always_comb begin
        busy = (state_q == WR_ADDR_DATA) || (state_q == WR_RESP) ||
               (state_q == RD_ADDR) || (state_q == RD_DATA);
        hit  = (TIMEOUT_CYCLES != 0) && busy && (cnt_q >= CNT_LAST);
    end

    // Timeout counter: cleared on accept, counts busy cycles, saturates with a sticky flag.
    always_comb begin
        cnt_d     = cnt_q;
        to_flag_d = to_flag_q;
        if (accept) begin
            cnt_d     = '0;
            to_flag_d = 1'b0;
        end else if (hit) begin
            cnt_d     = CNT_MAX;
            to_flag_d = 1'b1;
        end else if (busy && (TIMEOUT_CYCLES != 0)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Next-state and datapath capture for the transaction sequencer.
    always_comb begin
        state_d       = state_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
                if (m_axi_wvalid && m_axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)          state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    rsp_resp_d    = m_axi_bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = to_flag_q || hit;
                    state_d       = RESP;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rsp_resp_d    = m_axi_rresp;
                    rsp_rdata_d   = m_axi_rdata;
                    rsp_timeout_d = to_flag_q || hit;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; everything returns to zero/IDLE on reset.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q       <= IDLE;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            cnt_q         <= '0;
            to_flag_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            rst_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            cnt_q         <= cnt_d;
            to_flag_q     <= to_flag_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            rst_done_q    <= 1'b1;
        end
    end

    // AXI and response outputs decoded from state; payloads straight from registers.
    always_comb begin
        m_axi_awvalid = (state_q == WR_ADDR_DATA) && !aw_done_q;
        m_axi_wvalid  = (state_q == WR_ADDR_DATA) && !w_done_q;
        m_axi_bready  = (state_q == WR_RESP);
        m_axi_arvalid = (state_q == RD_ADDR);
        m_axi_rready  = (state_q == RD_DATA);
        rsp_valid     = (state_q == RESP);
        m_axi_awaddr  = addr_q;
        m_axi_araddr  = addr_q;
        m_axi_wdata   = wdata_q;
        m_axi_wstrb   = wstrb_q;
        m_axi_awprot  = rst_done_q ? AXI_PROT : 3'b000;
        m_axi_arprot  = rst_done_q ? AXI_PROT : 3'b000;
        rsp_rdata     = rsp_rdata_q;
        rsp_resp      = rsp_resp_q;
        rsp_timeout   = rsp_timeout_q;
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_axi_lite_master_seq.sv
// Bench for axi_lite_master_seq: a cycle-stepped AXI4-Lite slave with
// per-transaction channel delays, a byte-strobed memory model, and an
// expected-response queue predicted from the command and the chosen delays.
module tb_axi_lite_master_seq;

    localparam int TO     = 8;
    localparam int BUDGET = 120;

    logic        axi_aclk;
    logic        axi_aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_bad = 0;

    logic [34:0] exp_q[$];
    logic [31:0] rmem [logic [31:0]];
    logic [31:0] smem [logic [31:0]];

    axi_lite_master_seq #(
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(TO),
        .AXI_PROT      (3'b000)
    ) dut (
        .axi_aclk     (axi_aclk),
        .axi_aresetn  (axi_aresetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .rsp_timeout  (rsp_timeout),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awprot (m_axi_awprot),
        .m_axi_awready(m_axi_awready),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wready (m_axi_wready),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bready (m_axi_bready),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arprot (m_axi_arprot),
        .m_axi_arready(m_axi_arready),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rready (m_axi_rready),
        .dbg_state    (dbg_state)
    );

    // Clock and watchdog.
    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                m_axi_rready, rsp_valid, cmd_ready};
    endfunction

    function automatic logic [147:0] out_vec();
        return {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
                m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
                m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_bready,
                m_axi_arvalid, m_axi_araddr, m_axi_arprot, m_axi_rready};
    endfunction

    // Memory models: unwritten words read as an address-derived pattern.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : (a ^ 32'hC0DE_0000);
    endfunction

    function automatic logic [31:0] slv_read(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : (a ^ 32'hC0DE_0000);
    endfunction

    task automatic clear_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = '0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    endtask

    task automatic reset_pulse();
        clear_inputs();
        axi_aresetn = 1'b0;
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        exp_q.delete();
    endtask

    // One command end to end; called and returns at a falling edge. d1/d2/d3 are
    // aw/w/b delays for writes, ar/r delays for reads. rst_at >= 0 aborts with a
    // reset at that cycle instead of completing.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int d1, input int d2, input int d3,
                           input logic [1:0] resp, input int hold, input logic junk,
                           input int rst_at);
        int n, pred_ec, done_e, aw_e, w_e, ar_e, last_e;
        logic aw_d, w_d, ar_d, done, leaving;
        logic [31:0] exp_rd, cap_aw, cap_ar, cap_wd;
        logic [3:0] cap_ws;
        logic [34:0] exp_r;
        n = 0; done_e = 0; aw_e = 0; w_e = 0; ar_e = 0; last_e = 0;
        aw_d = 0; w_d = 0; ar_d = 0; done = 0; leaving = 0;
        cap_aw = '0; cap_ar = '0; cap_wd = '0; cap_ws = '0; exp_r = '0;

        // Completion edge counted from the accepting edge; every edge up to it is busy.
        pred_ec = wr ? 2 + ((d1 > d2) ? d1 : d2) + d3 : 2 + d1 + d2;
        if (wr) begin
            exp_rd = '0;
            rmem[addr] = merge(ref_read(addr), wdata, strb);
        end else begin
            exp_rd = ref_read(addr);
        end
        exp_q.push_back({(pred_ec >= TO), resp, exp_rd});

        check_val("cmd_ready_idle", 160'(cmd_ready), 160'(1'b1));
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        @(posedge axi_aclk);
        @(negedge axi_aclk);
        cmd_valid = 1'b0;
        check_val("prot", 160'({m_axi_awprot, m_axi_arprot}), 160'(6'b0));

        while (1) begin
            if (n >= BUDGET) begin
                check_val("txn_budget", 160'(n), 160'(pred_ec));
                reset_pulse();
                return;
            end
            if (n == rst_at) begin
                clear_inputs();
                axi_aresetn = 1'b0;
                #1;
                check_val("rst_async", 160'(out_vec()), 160'(0));
                @(negedge axi_aclk);
                axi_aresetn = 1'b1;
                #1;
                check_val("rst_release_ready", 160'(cmd_ready), 160'(1'b0));
                void'(exp_q.pop_back());
                for (int i = 0; i < 4; i++) begin
                    @(negedge axi_aclk);
                    check_val("post_rst_idle", 160'(ctrl_vec()), 160'(7'b0000001));
                end
                return;
            end
            if (leaving) begin
                check_val("exit_idle", 160'(ctrl_vec()), 160'(7'b0000001));
                clear_inputs();
                break;
            end

            check_val("ctrl", 160'(ctrl_vec()),
                      160'({wr & ~aw_d, wr & ~w_d, wr & aw_d & w_d & ~done,
                            ~wr & ~ar_d, ~wr & ar_d & ~done, done, 1'b0}));
            if (wr && !aw_d) check_val("awaddr", 160'(m_axi_awaddr), 160'(addr));
            if (wr && !w_d)  check_val("wdata_strb", 160'({m_axi_wstrb, m_axi_wdata}), 160'({strb, wdata}));
            if (!wr && !ar_d) check_val("araddr", 160'(m_axi_araddr), 160'(addr));
            if (done) check_val("rsp", 160'({rsp_timeout, rsp_resp, rsp_rdata}), 160'(exp_r));

            // Slave and consumer drive for the next rising edge.
            m_axi_awready = wr && !aw_d && (n >= d1);
            m_axi_wready  = wr && !w_d && (n >= d2);
            m_axi_bvalid  = wr && aw_d && w_d && !done && (n >= last_e + d3);
            m_axi_bresp   = m_axi_bvalid ? resp : 2'b00;
            m_axi_arready = !wr && !ar_d && (n >= d1);
            m_axi_rvalid  = !wr && ar_d && !done && (n >= ar_e + d2);
            m_axi_rdata   = m_axi_rvalid ? slv_read(cap_ar) : 32'h0;
            m_axi_rresp   = m_axi_rvalid ? resp : 2'b00;
            rsp_ready     = done && (n >= done_e + hold);
            cmd_valid     = junk && done && !rsp_ready;
            if (cmd_valid) begin
                cmd_write = ~wr; cmd_addr = 32'hFFFF_FFF0; cmd_wdata = 32'hBAD0_BAD0; cmd_wstrb = 4'hF;
            end

            // Handshakes that land on that edge.
            if (m_axi_awvalid && m_axi_awready) begin aw_d = 1; aw_e = n + 1; cap_aw = m_axi_awaddr; end
            if (m_axi_wvalid && m_axi_wready) begin
                w_d = 1; w_e = n + 1; cap_wd = m_axi_wdata; cap_ws = m_axi_wstrb;
            end
            if (aw_d && w_d) last_e = (aw_e > w_e) ? aw_e : w_e;
            if (m_axi_arvalid && m_axi_arready) begin ar_d = 1; ar_e = n + 1; cap_ar = m_axi_araddr; end
            if ((m_axi_bvalid && m_axi_bready) || (m_axi_rvalid && m_axi_rready)) begin
                check_val("done_edge", 160'(n + 1), 160'(pred_ec));
                if (wr) smem[cap_aw] = merge(slv_read(cap_aw), cap_wd, cap_ws);
                done   = 1;
                done_e = n + 1;
                exp_r  = exp_q.pop_front();
            end
            if (rsp_ready && rsp_valid) leaving = 1;

            @(negedge axi_aclk);
            n++;
        end
    endtask

    // Main sequence: reset, directed cases, then randomized traffic.
    initial begin
        logic        wr;
        logic [31:0] a, d;
        logic [3:0]  s;
        logic [1:0]  r;
        axi_aresetn = 1'b0;
        clear_inputs();
        repeat (3) @(negedge axi_aclk);
        check_val("reset_outputs", 160'(out_vec()), 160'(0));
        axi_aresetn = 1'b1;
        #1;
        check_val("ready_at_release", 160'(cmd_ready), 160'(1'b0));
        @(negedge axi_aclk);
        check_val("ready_after_release", 160'(cmd_ready), 160'(1'b1));

        // Basic write, always-ready slave.
        run_txn(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 0, 1'b0, -1);
        // wready three cycles ahead of awready.
        run_txn(1'b1, 32'h0000_0104, 32'h0102_0304, 4'h5, 3, 0, 0, 2'b00, 0, 1'b0, -1);
        // Read with SLVERR and a preloaded word.
        rmem[32'h4] = 32'h1234_5678;
        smem[32'h4] = 32'h1234_5678;
        run_txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 0, 2'b10, 0, 1'b0, -1);
        // bvalid twenty cycles late: timeout flagged, real bresp kept.
        run_txn(1'b1, 32'h0000_0108, 32'hCAFE_F00D, 4'hF, 0, 0, 20, 2'b01, 0, 1'b0, -1);
        // Timeout boundary: 7 counted cycles clean, 8 flagged.
        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 5, 0, 2'b00, 0, 1'b0, -1);
        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 6, 0, 2'b11, 0, 1'b0, -1);
        // Response held off five cycles while a competing command is offered.
        run_txn(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1, 1, 0, 2'b00, 5, 1'b1, -1);
        // Reset while waiting in RD_DATA, then prove the block is usable again.
        run_txn(1'b0, 32'h0000_0108, 32'h0, 4'h0, 0, 30, 0, 2'b00, 0, 1'b0, 3);
        run_txn(1'b0, 32'h0000_0108, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 32'h100 + 32'($urandom_range(0, 7)) * 4;
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            r  = 2'($urandom_range(0, 3));
            run_txn(wr, a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 2),
                    r, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
        end

        check_val("exp_q_empty", 160'(exp_q.size()), 160'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_seq.md
# axi_lite_master_seq

AXI4-Lite initiator that converts single register commands from a simple valid/ready command port into AXI4-Lite write or read transactions, then returns the result on a valid/ready response port. It sits upstream of the PL AXI4-Lite crossbar's slave port and drives the AD9361 core and FMC IIC controller registers from fabric logic (boot sequencers, test engines) instead of the PS. It keeps one transaction outstanding at a time and has a response timeout.

## Interface
- ADDR_WIDTH, 32, AXI address width
- TIMEOUT_CYCLES, 1024, cycles from the first valid before a timeout is flagged; 0 disables the timeout
- AXI_PROT, 3'b000, constant driven on m_axi_awprot and m_axi_arprot
- axi_aclk  in  1  clock; all logic is in this domain
- axi_aresetn  in  1  reset; asynchronous and active-low
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 selects write, 0 selects read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write strobes
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP value
- rsp_timeout  out  1  timeout fired during this transaction
- m_axi_aw{valid,addr,prot}, m_axi_awready  out/in  1,ADDR_WIDTH,3 / 1  write address channel
- m_axi_w{valid,data,strb}, m_axi_wready  out/in  1,32,4 / 1  write data channel
- m_axi_bvalid, m_axi_bresp, m_axi_bready  in,in,out  1,2,1  write response channel
- m_axi_ar{valid,addr,prot}, m_axi_arready  out/in  1,ADDR_WIDTH,3 / 1  read address channel
- m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rready  in,in,in,out  1,32,2,1  read data channel

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr, wdata, wstrb and cmd_write, clear the timeout counter, then go to WR_ADDR_DATA (write) or RD_ADDR (read).
- WR_ADDR_DATA: assert awvalid and wvalid together. Each valid drops independently on its own handshake, tracked by the flags aw_done and w_done. When both are done, go to WR_RESP. Same-cycle acceptance of both is legal.
- WR_RESP: bready=1. On bvalid, latch bresp, set rsp_rdata=0, go to RESP.
- RD_ADDR: arvalid=1. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, latch rdata and rresp, go to RESP.
- RESP: rsp_valid=1, with outputs held stable. On rsp_ready, go to IDLE.
- Timeout counter:
  - Increments every cycle in WR_ADDR_DATA, WR_RESP, RD_ADDR and RD_DATA.
  - Saturates at TIMEOUT_CYCLES and sets the sticky flag to_flag.
  - The AXI valid and ready signals are never withdrawn on timeout; the transaction still completes per the AXI spec.
  - When it completes, rsp_timeout=1 and rsp_resp reports the slave's actual response.
- Outputs m_axi_awaddr, araddr, wdata and wstrb come directly from the latched registers and are stable while the matching valid is high.
- cmd_ready=0 in every state except IDLE. A new command is never accepted while a response is pending.

## Timing
- Reset values:
  - All valid and ready outputs are 0, including rsp_valid.
  - cmd_ready=1 one cycle after reset release; it is 0 while reset is asserted.
  - rsp_rdata=0, rsp_resp=0, rsp_timeout=0, and all address, data and strb outputs are 0.
  - State is IDLE.
- Reset asserted mid-transaction forces every output to its reset value immediately (async). No transaction is resumed.
- Write latency with an always-ready slave and bvalid one cycle after the W handshake:
  - cycle 0: cmd accepted
  - cycle 1: aw/w handshake
  - cycle 2: bvalid/bready handshake
  - cycle 3: rsp_valid=1
- Read latency with an always-ready slave and rvalid one cycle after the AR handshake:
  - cycle 0: cmd accepted
  - cycle 1: ar handshake
  - cycle 2: r handshake
  - cycle 3: rsp_valid=1
- If rsp_ready is held high, RESP lasts 1 cycle, and the next command can be accepted on the cycle after RESP.
- Timeout fires after exactly TIMEOUT_CYCLES counted cycles. The flag is sampled at completion; if completion and saturation happen in the same cycle, rsp_timeout=1.

## Test plan
- Write addr=0x0000_0100, data=0xDEADBEEF, strb=0xF, slave always ready with bresp=0:
  - awvalid and wvalid are high together for 1 cycle with correct payload.
  - rsp_valid appears at cycle 3 with rsp_resp=0, rsp_rdata=0, rsp_timeout=0.
- Write where the slave asserts wready 3 cycles before awready:
  - wvalid drops after its handshake while awvalid stays high.
  - bready rises only after both handshakes.
  - Exactly one response is returned.
- Read addr=0x0000_0004, slave returns 0x12345678 with rresp=2'b10:
  - rsp_rdata=0x12345678, rsp_resp=2'b10.
  - arvalid is high until arready; rready rises only in RD_DATA.
- TIMEOUT_CYCLES=8, bvalid delayed 20 cycles:
  - bready stays high throughout the wait.
  - The response is delivered after bvalid with rsp_timeout=1 and rsp_resp equal to the slave's bresp.
- rsp_ready held low 5 cycles:
  - rsp_* stay stable and cmd_ready stays 0.
  - cmd_valid asserted during this window is not accepted.
  - The command is accepted the cycle after RESP exits.
- axi_aresetn pulsed low while in RD_DATA:
  - All outputs go to reset values asynchronously.
  - cmd_ready=1 the cycle after release, and no stale response appears.
